// File: rtl/cook_timer.sv
`default_nettype none
// ============================================================================
// Module      : cook_timer
// Description : MM:SS BCD cook-time countdown for the microwave controller.
//               Keypad digit entry, start/pause/clear control, door
//               interlock, magnetron enable and done indication. The time
//               decrements once every TICKS_PER_SEC tick_in pulses.
//               Optional feature macro: QUICK_START_EN (start at 00:00 loads
//               00:30; start while running adds 30 s, saturating at 99:59).
// Revision    : 1.0 - initial release
// ============================================================================
module cook_timer #(
  parameter int TICKS_PER_SEC = 10,
  parameter int PRESC_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  state_t             state;
  logic [PRESC_W-1:0] presc;

  logic       time_zero;
  logic       digit_ok;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       dec_zero;

  assign time_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign digit_ok  = key_valid && (key_digit <= 4'd9);

  // One-second BCD decrement with borrow chain; seconds tens wraps 0 -> 5.
  always_comb begin
    dec_so = sec_ones - 4'd1;
    dec_st = sec_tens;
    dec_mo = min_ones;
    dec_mt = min_tens;
    if (sec_ones == 4'd0) begin
      dec_so = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_st = sec_tens - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones != 4'd0) begin
          dec_mo = min_ones - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                    (dec_st == 4'd0) && (dec_so == 4'd0);

`ifdef QUICK_START_EN
  logic [3:0] add_mt, add_mo, add_st, add_so;
  logic [3:0] st_sum;

  // Add 30 s: +3 on seconds tens with carry into minutes; overflow past
  // 99 minutes pins the display at 99:59.
  always_comb begin
    st_sum = sec_tens + 4'd3;
    add_so = sec_ones;
    add_st = st_sum;
    add_mo = min_ones;
    add_mt = min_tens;
    if (st_sum >= 4'd6) begin
      add_st = st_sum - 4'd6;
      if (min_ones >= 4'd9) begin
        add_mo = 4'd0;
        if (min_tens >= 4'd9) begin
          add_mt = 4'd9;
          add_mo = 4'd9;
          add_st = 4'd5;
          add_so = 4'd9;
        end else begin
          add_mt = min_tens + 4'd1;
        end
      end else begin
        add_mo = min_ones + 4'd1;
      end
    end
  end
`endif

  // Control FSM with digit registers, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stop_clear) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (start) begin
            // A start request consumes the cycle even when it is rejected.
            if (!door_open && !time_zero) begin
              presc  <= '0;
              state  <= S_RUNNING;
              mag_on <= 1'b1;
            end
`ifdef QUICK_START_EN
            else if (!door_open) begin
              sec_tens <= 4'd3;
              presc    <= '0;
              state    <= S_RUNNING;
              mag_on   <= 1'b1;
            end
`endif
          end else if (digit_ok) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= key_digit;
          end
        end

        S_RUNNING: begin
          if (stop_clear || door_open) begin
            state  <= S_PAUSED;
            mag_on <= 1'b0;
          end
`ifdef QUICK_START_EN
          else if (start) begin
            min_tens <= add_mt;
            min_ones <= add_mo;
            sec_tens <= add_st;
            sec_ones <= add_so;
          end
`endif
          else if (tick_in) begin
            if (presc == PRESC_LAST) begin
              presc    <= '0;
              min_tens <= dec_mt;
              min_ones <= dec_mo;
              sec_tens <= dec_st;
              sec_ones <= dec_so;
              if (dec_zero) begin
                state  <= S_DONE;
                mag_on <= 1'b0;
                done   <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
        end

        S_PAUSED: begin
          if (stop_clear) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            presc    <= '0;
            state    <= S_IDLE;
          end else if (start && !door_open) begin
            // Prescaler kept so a partial second resumes where it stopped.
            state  <= S_RUNNING;
            mag_on <= 1'b1;
          end
        end

        S_DONE: begin
          // Any user action acknowledges completion; the key itself is dropped.
          if (stop_clear || door_open || start || digit_ok) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          mag_on <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cook_timer
// Description : Self-checking bench for cook_timer. A minutes/seconds model
//               is compared on every cycle; literal expectations pin the
//               model at the key points of each scenario. Honours
//               QUICK_START_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cook_timer;

  localparam int TPS = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       mag_on, done;

  always #5 clk = ~clk;

  cook_timer #(.TICKS_PER_SEC(TPS), .PRESC_W(4)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
    .door_open(door_open), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .mag_on(mag_on), .done(done)
  );

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  // Model: mode 0 idle, 1 running, 2 paused, 3 done; time as minutes+seconds.
  int m_mode = 0;
  int m_min  = 0;
  int m_sec  = 0;
  int m_pre  = 0;

  always @(posedge clk) begin
    int n;
    if (reset) begin
      m_mode = 0; m_min = 0; m_sec = 0; m_pre = 0;
    end else begin
      case (m_mode)
        0: begin
          if (stop_clear) begin
            m_min = 0; m_sec = 0;
          end else if (start) begin
            if (!door_open && (m_min != 0 || m_sec != 0)) begin
              m_pre = 0; m_mode = 1;
            end
`ifdef QUICK_START_EN
            else if (!door_open) begin
              m_sec = 30; m_pre = 0; m_mode = 1;
            end
`endif
          end else if (key_valid && key_digit <= 4'd9) begin
            n = ((m_min * 100 + m_sec) % 1000) * 10 + int'(key_digit);
            m_min = n / 100;
            m_sec = n % 100;
          end
        end
        1: begin
          if (stop_clear || door_open) begin
            m_mode = 2;
          end
`ifdef QUICK_START_EN
          else if (start) begin
            m_sec = m_sec + 30;
            if (m_sec >= 60) begin
              m_sec = m_sec - 60;
              m_min = m_min + 1;
            end
            if (m_min > 99) begin
              m_min = 99; m_sec = 59;
            end
          end
`endif
          else if (tick_in) begin
            if (m_pre == TPS - 1) begin
              m_pre = 0;
              if (m_sec > 0) m_sec = m_sec - 1;
              else begin
                m_min = m_min - 1; m_sec = 59;
              end
              if (m_min == 0 && m_sec == 0) m_mode = 3;
            end else begin
              m_pre = m_pre + 1;
            end
          end
        end
        2: begin
          if (stop_clear) begin
            m_min = 0; m_sec = 0; m_pre = 0; m_mode = 0;
          end else if (start && !door_open) begin
            m_mode = 1;
          end
        end
        default: begin
          if (stop_clear || door_open || start || (key_valid && key_digit <= 4'd9))
            m_mode = 0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_min_tens", 32'(min_tens), 32'(m_min / 10));
      chk("cyc_min_ones", 32'(min_ones), 32'(m_min % 10));
      chk("cyc_sec_tens", 32'(sec_tens), 32'(m_sec / 10));
      chk("cyc_sec_ones", 32'(sec_ones), 32'(m_sec % 10));
      chk("cyc_mag_on",   32'(mag_on),   32'(m_mode == 1));
      chk("cyc_done",     32'(done),     32'(m_mode == 3));
    end
  end

  task automatic lit(input string name, input int mt, input int mo, input int st,
                     input int so, input int mg, input int dn);
    chk({name, "_mt"},  32'(min_tens), 32'(mt));
    chk({name, "_mo"},  32'(min_ones), 32'(mo));
    chk({name, "_st"},  32'(sec_tens), 32'(st));
    chk({name, "_so"},  32'(sec_ones), 32'(so));
    chk({name, "_mag"}, 32'(mag_on),   32'(mg));
    chk({name, "_dn"},  32'(done),     32'(dn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick_in = 1'b0; key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0;
  endtask

  task automatic key(input int d);
    key_digit = 4'(d); key_valid = 1'b1; step();
  endtask

  task automatic press_start();
    start = 1'b1; step();
  endtask

  task automatic press_stop();
    stop_clear = 1'b1; step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1; step(); step();
    end
  endtask

  initial begin
    step();
    cmp_en = 1'b1;
    step();
    reset = 1'b0;
    lit("reset", 0, 0, 0, 0, 0, 0);

    // T1: 01:30 entry, one second after 10 ticks
    key(1); key(3); key(0);
    lit("t1_entry", 0, 1, 3, 0, 0, 0);
    press_start();
    lit("t1_run", 0, 1, 3, 0, 1, 0);
    ticks(9);
    lit("t1_9ticks", 0, 1, 3, 0, 1, 0);
    ticks(1);
    lit("t1_10ticks", 0, 1, 2, 9, 1, 0);
    press_stop(); press_stop();
    lit("t1_clear", 0, 0, 0, 0, 0, 0);

    // T2: minute borrow, then countdown to done
    key(1); key(0); key(0);
    press_start();
    ticks(10);
    lit("t2_borrow", 0, 0, 5, 9, 1, 0);
    press_stop(); press_stop();
    key(2);
    press_start();
    ticks(19);
    tick_in = 1'b1; step();
    lit("t2_done", 0, 0, 0, 0, 0, 1);
    press_start();
    lit("t2_ack", 0, 0, 0, 0, 0, 0);

    // T3: door interlock with partial second retained
    key(4); key(5);
    press_start();
    ticks(7);
    door_open = 1'b1; tick_in = 1'b1; step();
    lit("t3_door", 0, 0, 4, 5, 0, 0);
    ticks(3);
    press_start();
    lit("t3_start_door_open", 0, 0, 4, 5, 0, 0);
    door_open = 1'b0; step();
    press_start();
    lit("t3_resume", 0, 0, 4, 5, 1, 0);
    ticks(2);
    lit("t3_2ticks", 0, 0, 4, 5, 1, 0);
    ticks(1);
    lit("t3_3ticks", 0, 0, 4, 4, 1, 0);

    // T4: stop_clear beats a terminal tick; then clear; invalid key ignored
    ticks(9);
    stop_clear = 1'b1; tick_in = 1'b1; step();
    lit("t4_pause", 0, 0, 4, 4, 0, 0);
    press_stop();
    lit("t4_clear", 0, 0, 0, 0, 0, 0);
    key(12);
    lit("t4_key12", 0, 0, 0, 0, 0, 0);

    // Maximum entry and non-normalised seconds
    key(9); key(9); key(9); key(9);
    press_start();
    ticks(10);
    lit("max_dec", 9, 9, 9, 8, 1, 0);
    press_stop(); press_stop();
    key(1); key(7); key(0);
    press_start();
    ticks(10);
    lit("odd_dec", 0, 1, 6, 9, 1, 0);
    press_stop(); press_stop();

    // Done acknowledged by a key, which is not shifted in
    key(1);
    press_start();
    ticks(10);
    lit("key_done", 0, 0, 0, 0, 0, 1);
    key(7);
    lit("key_ack", 0, 0, 0, 0, 0, 0);

    // T5: start at 00:00
`ifdef QUICK_START_EN
    press_start();
    lit("t5_qs", 0, 0, 3, 0, 1, 0);
    press_stop(); press_stop();
    key(4); key(5);
    press_start(); press_start();
    lit("t5_add", 0, 1, 1, 5, 1, 0);
    press_stop(); press_stop();
    key(9); key(9); key(4); key(5);
    press_start(); press_start();
    lit("t5_sat", 9, 9, 5, 9, 1, 0);
    press_stop(); press_stop();
`else
    press_start();
    lit("t5_nostart", 0, 0, 0, 0, 0, 0);
`endif

    // T6: reset mid-countdown
    key(5); key(0); key(0);
    press_start();
    ticks(3);
    reset = 1'b1; step();
    reset = 1'b0;
    lit("t6_reset", 0, 0, 0, 0, 0, 0);
    step(); step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
